// File: rtl/gon_pe_input_buffer_if.sv
// Handshake bundle between the GON multicast controller, the PE input buffer and the PE.
// The master drives words in and pops elements out; the slave is the buffer itself.
interface gon_pe_input_buffer_if #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned ELEM_WIDTH = 16,
    parameter int unsigned DEPTH      = 4
);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [DATA_WIDTH-1:0] data_in;
    logic                  enable_in;
    logic                  ready_out;
    logic [ELEM_WIDTH-1:0] elem_out;
    logic                  elem_valid;
    logic                  elem_pop;
    logic [CNT_W-1:0]      word_count;

    modport master (
        output data_in, enable_in, elem_pop,
        input  ready_out, elem_out, elem_valid, word_count
    );

    modport slave (
        input  data_in, enable_in, elem_pop,
        output ready_out, elem_out, elem_valid, word_count
    );
endinterface

// File: rtl/gon_pe_input_buffer.sv
// Circular word buffer behind the GON multicast controller; unpacks each word into
// ELEM_WIDTH-bit lanes (LSB first) for the PE over a valid/pop handshake.
module gon_pe_input_buffer #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned ELEM_WIDTH = 16,
    parameter int unsigned DEPTH      = 4
) (
    input logic                 link_clk,
    input logic                 reset,
    gon_pe_input_buffer_if.slave bus
);
    localparam int unsigned LANES  = DATA_WIDTH / ELEM_WIDTH;
    localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
    localparam int unsigned LANE_W = (LANES > 1) ? $clog2(LANES) : 1;

    localparam logic [PTR_W-1:0]  PTR_ONE   = PTR_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(DEPTH);
    localparam logic [LANE_W-1:0] LANE_ONE  = LANE_W'(1);
    localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(LANES - 1);

    typedef enum logic [0:0] {StEmpty, StActive} state_e;

    state_e              state_q, state_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [LANE_W-1:0]   lane_q, lane_d;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic                  ready;
    logic                  valid;
    logic                  wr_acc;
    logic                  pop_acc;
    logic                  deq;
    logic [DATA_WIDTH-1:0] head;
    logic [ELEM_WIDTH-1:0] lanes [LANES];

    // Ready comes from registered state only, so a full buffer stalls the bus even
    // in a cycle where the PE is about to dequeue.
    assign ready   = (count_q < CNT_FULL) & reset;
    assign valid   = (state_q == StActive);
    assign wr_acc  = bus.enable_in & ready;
    assign pop_acc = bus.elem_pop & valid;
    assign deq     = pop_acc & (lane_q == LANE_LAST);
    assign head    = mem_q[rd_ptr_q];

    always_comb begin
        for (int k = 0; k < LANES; k++) begin
            lanes[k] = head[k*ELEM_WIDTH +: ELEM_WIDTH];
        end
    end

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        lane_d   = lane_q;

        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop_acc) begin
            lane_d = (lane_q == LANE_LAST) ? '0 : lane_q + LANE_ONE;
        end
        if (deq) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end

        case ({wr_acc, deq})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        unique case (state_q)
            StEmpty: begin
                if (wr_acc) state_d = StActive;
            end
            StActive: begin
                if (deq && !wr_acc && count_q == CNT_ONE) state_d = StEmpty;
            end
            default: state_d = StEmpty;
        endcase
    end

    always_ff @(posedge link_clk) begin
        if (!reset) begin
            state_q  <= StEmpty;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            lane_q   <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            lane_q   <= lane_d;
        end
    end

    // Storage needs no reset; wr_acc is already gated by reset through ready.
    always_ff @(posedge link_clk) begin
        if (wr_acc) begin
            mem_q[wr_ptr_q] <= bus.data_in;
        end
    end

    assign bus.ready_out  = ready;
    assign bus.elem_valid = valid;
    assign bus.elem_out   = valid ? lanes[lane_q] : '0;
    assign bus.word_count = count_q;
endmodule

// File: doc/gon_pe_input_buffer.md
# gon_pe_input_buffer

Word buffer and element unpacker that sits directly downstream of a PE's global-on-chip-network multicast controller. It accepts DATA_WIDTH-bit GON words when the controller asserts enable. It drives the ready back to the controller. It presents the buffered words to the PE one ELEM_WIDTH-bit element at a time, using a valid/pop handshake. Back-pressure reaches the controller's ready_in directly, so a full buffer stalls the multicast bus.

## Interface
- DATA_WIDTH, 64: GON word width; must equal the multicast controller's data width.
- ELEM_WIDTH, 16: PE element width; DATA_WIDTH must be an integer multiple of it. LANES = DATA_WIDTH/ELEM_WIDTH.
- DEPTH, 4: word entries; power of two, >= 2.

Ports:
- link_clk  in  1  single clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-low (0 = reset).
- data_in  in  DATA_WIDTH  GON word from the multicast controller; may be high-Z while enable_in = 0, so it is sampled only on an accepted write.
- enable_in  in  1  write strobe from the controller.
- ready_out  out  1  to the controller's ready_in; 1 = a word can be accepted this cycle.
- elem_out  out  ELEM_WIDTH  current element to the PE.
- elem_valid  out  1  elem_out holds a valid element.
- elem_pop  in  1  PE consumes elem_out this cycle.
- word_count  out  $clog2(DEPTH+1)  number of occupied word entries.

## Operation
- Storage is a circular buffer of DEPTH words, with a write pointer, a read pointer, a count, and a lane index (0..LANES-1).
- Write accept: `enable_in & ready_out` at a rising edge.
  - data_in goes into mem[wr_ptr].
  - wr_ptr increments and wraps from DEPTH-1 to 0.
- ready_out = (count < DEPTH) & reset. It is derived from registered state only; there is no same-cycle bypass from a dequeue.
- If enable_in = 1 while ready_out = 0, the word is dropped and no state changes.
- Element lanes are ordered LSB first: lane k = head_word[k*ELEM_WIDTH +: ELEM_WIDTH].
- elem_valid = (count != 0).
- elem_out = lane[lane_idx] of mem[rd_ptr] when elem_valid = 1, else all zeros.
- Pop accept: `elem_pop & elem_valid`.
  - If lane_idx < LANES-1: lane_idx increments.
  - If lane_idx = LANES-1: lane_idx returns to 0, the word is dequeued, and rd_ptr increments and wraps.
- elem_pop while elem_valid = 0 is ignored.
- Count update:
  - +1 on write accept alone.
  - -1 on dequeue alone.
  - Unchanged when a write accept and a dequeue occur in the same cycle.
- Read side as a state machine: EMPTY (count = 0) -> ACTIVE (count > 0) on write accept; ACTIVE -> EMPTY on dequeue with no simultaneous write when count = 1.
- Reset (reset = 0 at an edge) clears pointers, count and lane_idx. Memory contents are don't-care. An in-flight word or a partially consumed word is discarded.

## Timing
- Output values while reset is held low, and after the reset edge:
  - ready_out = 0 while reset = 0 (combinational gating), and 1 in the first cycle after reset releases.
  - elem_valid = 0.
  - elem_out = 0.
  - word_count = 0.
- Write-to-read latency is 1 cycle. A word accepted at edge N gives elem_valid = 1 and elem_out = lane 0 after edge N.
- Each element pop takes effect at the edge; the next lane is visible in the following cycle. A word therefore takes LANES pop cycles to drain, at one element per cycle maximum.
- Full: after DEPTH writes with no dequeue, ready_out = 0 from the cycle after the DEPTH-th accept. It returns to 1 in the cycle after the dequeue edge.
- Simultaneous write and dequeue with count = DEPTH is impossible, because ready_out = 0. With 0 < count < DEPTH, both are accepted.
- Sustained throughput: one word in per cycle is accepted until full. Drain rate is one word per LANES cycles.

## Test plan
- Reset check: hold reset = 0 for 2 cycles while driving enable_in = 1 -> ready_out = 0, elem_valid = 0, word_count = 0, and no write occurs. After release, ready_out = 1.
- Single word: write 0x0004_0003_0002_0001 with pop held at 1 -> elem_out = 0x0001, 0x0002, 0x0003, 0x0004 on consecutive cycles starting 1 cycle after the write. Then elem_valid = 0 and word_count = 0.
- Fill to full (DEPTH = 4): 5 back-to-back writes with no pops -> word_count = 4 and ready_out = 0 after the 4th. The 5th word is dropped. After 4 pops, ready_out = 1 in the next cycle.
- Simultaneous write and dequeue at count = 2 -> word_count stays 2, and element order is preserved across the pointer wrap (more than 8 words streamed with no loss or reorder).
- Pop on empty, and a pop gap in mid-word (pause elem_pop for 3 cycles at lane 2) -> no state change while paused, and elem_out holds lane 2.
- Reset mid-word at lane_idx = 1 with count = 3 -> all state cleared. The next write is read from lane 0.
